// File: rtl/idex_pkg.sv
// ---------------------------------------------------------------------------
// idex_pkg
// Shared constants for the ID/EX pipeline boundary.
//   ALU_*    : 4-bit ALU control codes presented to EX.
//   ALUOP_*  : 2-bit ALU operation class produced by the main decoder.
//   ALU_BUBBLE : ALU code loaded when a bubble is inserted (harmless ADD).
// ---------------------------------------------------------------------------
package idex_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;
   localparam logic [3:0] ALU_SLT = 4'b1000;
   localparam logic [3:0] ALU_MUL = 4'b1111;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   // A bubble decodes as ADD so EX computes something benign.
   localparam logic [3:0] ALU_BUBBLE = ALU_ADD;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ---------------------------------------------------------------------------
// alu_ctrl_dec
// Combinational ALU control decoder.
// Ports:
//   aluop_i    [1:0] ALU operation class (mem / branch / R-type / I-type)
//   funct3_i   [2:0] instruction funct3
//   funct7_i   [6:0] instruction funct7
//   alu_ctrl_o [3:0] ALU control code
//   illegal_o        unsupported encoding (code falls back to ADD)
// ---------------------------------------------------------------------------
module alu_ctrl_dec
   import idex_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output logic [3:0] alu_ctrl_o,
   output logic       illegal_o
);

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      illegal_o  = 1'b0;
      case (aluop_i)
         ALUOP_MEM: alu_ctrl_o = ALU_ADD;
         ALUOP_BR:  alu_ctrl_o = ALU_SUB;
         ALUOP_R: begin
            case ({funct7_i, funct3_i})
               10'b0000000_000: alu_ctrl_o = ALU_ADD;
               10'b0100000_000: alu_ctrl_o = ALU_SUB;
               10'b0000000_111: alu_ctrl_o = ALU_AND;
               10'b0000000_110: alu_ctrl_o = ALU_OR;
               10'b0000000_100: alu_ctrl_o = ALU_XOR;
               10'b0000000_001: alu_ctrl_o = ALU_SLL;
               10'b0000000_101: alu_ctrl_o = ALU_SRL;
               10'b0100000_101: alu_ctrl_o = ALU_SRA;
               10'b0000000_010: alu_ctrl_o = ALU_SLT;
               10'b0000001_000: alu_ctrl_o = ALU_MUL;
               default:         illegal_o  = 1'b1;
            endcase
         end
         default: begin
            // I-type: funct7 only matters for the shift-immediate forms,
            // elsewhere those bits belong to the immediate.
            case (funct3_i)
               3'b000: alu_ctrl_o = ALU_ADD;
               3'b111: alu_ctrl_o = ALU_AND;
               3'b110: alu_ctrl_o = ALU_OR;
               3'b100: alu_ctrl_o = ALU_XOR;
               3'b010: alu_ctrl_o = ALU_SLT;
               3'b001: begin
                  if (funct7_i == 7'b0000000) alu_ctrl_o = ALU_SLL;
                  else                        illegal_o  = 1'b1;
               end
               3'b101: begin
                  if (funct7_i == 7'b0000000)      alu_ctrl_o = ALU_SRL;
                  else if (funct7_i == 7'b0100000) alu_ctrl_o = ALU_SRA;
                  else                             illegal_o  = 1'b1;
               end
               default: illegal_o = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/idex_stage_reg.sv
// ---------------------------------------------------------------------------
// idex_stage_reg
// Registered ID/EX boundary. Decodes the ALU control code and selects ALU
// operand 2 combinationally, then captures everything on the rising edge.
// Edge priority: reset (async) > flush (bubble) > stall (hold) > load.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   stall_i, flush_i             hazard hold / bubble insertion
//   valid_i                      ID holds a real instruction
//   rs1_data_i, rs2_data_i       register read data
//   iimm_i, simm_i               sign-extended I / S immediates
//   rs1_addr_i, rs2_addr_i, rd_addr_i  register addresses
//   funct3_i, funct7_i           instruction function fields
//   wb_i, mem_i                  RegWrite, {MemRead, MemWrite}
//   aluop_i, alusrc_i            ALU class, operand-2 select (1 = imm)
//   *_o                          registered versions presented to EX
//   alu_ctrl_o, illegal_o        registered ALU code / unsupported flag
// ---------------------------------------------------------------------------
module idex_stage_reg
   import idex_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic               flush_i,
   input  logic               valid_i,
   input  logic [XLEN-1:0]    rs1_data_i,
   input  logic [XLEN-1:0]    rs2_data_i,
   input  logic [XLEN-1:0]    iimm_i,
   input  logic [XLEN-1:0]    simm_i,
   input  logic [RADDR_W-1:0] rs1_addr_i,
   input  logic [RADDR_W-1:0] rs2_addr_i,
   input  logic [RADDR_W-1:0] rd_addr_i,
   input  logic [2:0]         funct3_i,
   input  logic [6:0]         funct7_i,
   input  logic               wb_i,
   input  logic [1:0]         mem_i,
   input  logic [1:0]         aluop_i,
   input  logic               alusrc_i,
   output logic               valid_o,
   output logic [XLEN-1:0]    val1_o,
   output logic [XLEN-1:0]    val2_o,
   output logic [XLEN-1:0]    simm_o,
   output logic [3:0]         alu_ctrl_o,
   output logic [RADDR_W-1:0] rs1_addr_o,
   output logic [RADDR_W-1:0] rs2_addr_o,
   output logic [RADDR_W-1:0] rd_addr_o,
   output logic               wb_o,
   output logic [1:0]         mem_o,
   output logic               illegal_o
);

   logic [3:0]         dec_alu;
   logic               dec_ill;

   logic               valid_q,   valid_d;
   logic [XLEN-1:0]    val1_q,    val1_d;
   logic [XLEN-1:0]    val2_q,    val2_d;
   logic [XLEN-1:0]    simm_q,    simm_d;
   logic [3:0]         alu_q,     alu_d;
   logic [RADDR_W-1:0] rs1_q,     rs1_d;
   logic [RADDR_W-1:0] rs2_q,     rs2_d;
   logic [RADDR_W-1:0] rd_q,      rd_d;
   logic               wb_q,      wb_d;
   logic [1:0]         mem_q,     mem_d;
   logic               ill_q,     ill_d;

   alu_ctrl_dec u_dec (
      .aluop_i    (aluop_i),
      .funct3_i   (funct3_i),
      .funct7_i   (funct7_i),
      .alu_ctrl_o (dec_alu),
      .illegal_o  (dec_ill)
   );

   // Load values. Side effects (write-back, memory, illegal trap) are
   // suppressed for an empty slot; data fields pass through untouched.
   always_comb begin
      valid_d = valid_i;
      val1_d  = rs1_data_i;
      val2_d  = alusrc_i ? iimm_i : rs2_data_i;
      simm_d  = simm_i;
      alu_d   = dec_alu;
      rs1_d   = rs1_addr_i;
      rs2_d   = rs2_addr_i;
      rd_d    = rd_addr_i;
      wb_d    = valid_i & wb_i;
      mem_d   = valid_i ? mem_i : 2'b00;
      ill_d   = valid_i & dec_ill;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         val1_q  <= '0;
         val2_q  <= '0;
         simm_q  <= '0;
         alu_q   <= 4'b0000;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         wb_q    <= 1'b0;
         mem_q   <= 2'b00;
         ill_q   <= 1'b0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
         val1_q  <= '0;
         val2_q  <= '0;
         simm_q  <= '0;
         alu_q   <= ALU_BUBBLE;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         wb_q    <= 1'b0;
         mem_q   <= 2'b00;
         ill_q   <= 1'b0;
      end else if (!stall_i) begin
         valid_q <= valid_d;
         val1_q  <= val1_d;
         val2_q  <= val2_d;
         simm_q  <= simm_d;
         alu_q   <= alu_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         wb_q    <= wb_d;
         mem_q   <= mem_d;
         ill_q   <= ill_d;
      end
   end

   assign valid_o    = valid_q;
   assign val1_o     = val1_q;
   assign val2_o     = val2_q;
   assign simm_o     = simm_q;
   assign alu_ctrl_o = alu_q;
   assign rs1_addr_o = rs1_q;
   assign rs2_addr_o = rs2_q;
   assign rd_addr_o  = rd_q;
   assign wb_o       = wb_q;
   assign mem_o      = mem_q;
   assign illegal_o  = ill_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
module tb_idex_stage_reg;

   typedef struct packed {
      logic        stall;
      logic        flush;
      logic        valid;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] iimm;
      logic [31:0] simm;
      logic [4:0]  rs1a;
      logic [4:0]  rs2a;
      logic [4:0]  rda;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        wb;
      logic [1:0]  mem;
      logic [1:0]  aluop;
      logic        alusrc;
   } in_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] val1;
      logic [31:0] val2;
      logic [31:0] simm;
      logic [3:0]  alu;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        wb;
      logic [1:0]  mem;
      logic        ill;
   } out_t;

   typedef struct packed {
      in_t         in;
      logic [3:0]  e_alu;
      logic        e_ill;
      logic        e_valid;
      logic        e_wb;
      logic [1:0]  e_mem;
      logic [31:0] e_val2;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   logic        stall_i, flush_i, valid_i;
   logic [31:0] rs1_data_i, rs2_data_i, iimm_i, simm_i;
   logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
   logic [2:0]  funct3_i;
   logic [6:0]  funct7_i;
   logic        wb_i;
   logic [1:0]  mem_i, aluop_i;
   logic        alusrc_i;
   logic        valid_o, wb_o, illegal_o;
   logic [31:0] val1_o, val2_o, simm_o;
   logic [3:0]  alu_ctrl_o;
   logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
   logic [1:0]  mem_o;

   idex_stage_reg #(.XLEN(32), .RADDR_W(5)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .iimm_i(iimm_i), .simm_i(simm_i), .rs1_addr_i(rs1_addr_i),
      .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .funct3_i(funct3_i),
      .funct7_i(funct7_i), .wb_i(wb_i), .mem_i(mem_i), .aluop_i(aluop_i),
      .alusrc_i(alusrc_i), .valid_o(valid_o), .val1_o(val1_o),
      .val2_o(val2_o), .simm_o(simm_o), .alu_ctrl_o(alu_ctrl_o),
      .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
      .rd_addr_o(rd_addr_o), .wb_o(wb_o), .mem_o(mem_o),
      .illegal_o(illegal_o)
   );

   int   total = 0;
   int   bad   = 0;
   out_t exp_s;

   // ---------------- reference model ----------------
   // Supported R-type {funct7,funct3} keys and their ALU codes, as a table.
   logic [9:0] r_key  [10];
   logic [3:0] r_code [10];

   function automatic void ref_decode(input logic [1:0] aluop,
                                      input logic [2:0] f3,
                                      input logic [6:0] f7,
                                      output logic [3:0] code,
                                      output logic ill);
      code = 4'b0010;
      ill  = 1'b1;
      if (aluop == 2'b00) begin
         ill = 1'b0;
      end else if (aluop == 2'b01) begin
         code = 4'b0110; ill = 1'b0;
      end else if (aluop == 2'b10) begin
         for (int k = 0; k < 10; k++)
            if (r_key[k] == {f7, f3}) begin code = r_code[k]; ill = 1'b0; end
      end else begin
         // I-type: non-shifts ignore funct7; shifts use the R-type table.
         if (f3 == 3'b001 || f3 == 3'b101) begin
            for (int k = 0; k < 10; k++)
               if (r_key[k] == {f7, f3}) begin code = r_code[k]; ill = 1'b0; end
         end else if (f3 != 3'b011) begin
            for (int k = 0; k < 10; k++)
               if (r_key[k] == {7'b0000000, f3}) begin code = r_code[k]; ill = 1'b0; end
         end
      end
   endfunction

   function automatic out_t model_next(input out_t cur, input in_t v);
      out_t n;
      logic [3:0] c;
      logic       il;
      n = cur;
      if (v.flush) begin
         n = '0;
         n.alu = 4'b0010;
      end else if (!v.stall) begin
         ref_decode(v.aluop, v.f3, v.f7, c, il);
         n.valid = v.valid;
         n.val1  = v.rs1d;
         n.val2  = v.alusrc ? v.iimm : v.rs2d;
         n.simm  = v.simm;
         n.alu   = c;
         n.rs1   = v.rs1a;
         n.rs2   = v.rs2a;
         n.rd    = v.rda;
         n.wb    = v.valid && v.wb;
         n.mem   = v.valid ? v.mem : 2'b00;
         n.ill   = v.valid && il;
      end
      return n;
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input in_t v);
      stall_i = v.stall;   flush_i = v.flush;   valid_i = v.valid;
      rs1_data_i = v.rs1d; rs2_data_i = v.rs2d;
      iimm_i = v.iimm;     simm_i = v.simm;
      rs1_addr_i = v.rs1a; rs2_addr_i = v.rs2a; rd_addr_i = v.rda;
      funct3_i = v.f3;     funct7_i = v.f7;
      wb_i = v.wb;         mem_i = v.mem;
      aluop_i = v.aluop;   alusrc_i = v.alusrc;
   endtask

   task automatic apply(input in_t v);
      drive(v);
      exp_s = model_next(exp_s, v);
      @(posedge clk_i);
      #1;
   endtask

   function automatic in_t mk(input logic [1:0] aluop, input logic [6:0] f7,
                              input logic [2:0] f3, input logic valid,
                              input logic wb, input logic [1:0] mem,
                              input logic alusrc, input logic [31:0] rs1d,
                              input logic [31:0] rs2d, input logic [31:0] iimm,
                              input logic [31:0] simm);
      in_t v;
      v = '0;
      v.aluop = aluop; v.f7 = f7; v.f3 = f3; v.valid = valid; v.wb = wb;
      v.mem = mem; v.alusrc = alusrc; v.rs1d = rs1d; v.rs2d = rs2d;
      v.iimm = iimm; v.simm = simm;
      v.rs1a = 5'd1; v.rs2a = 5'd2; v.rda = 5'd3;
      return v;
   endfunction

   function automatic in_t rnd_in();
      in_t v;
      int  r;
      v.stall  = ($urandom_range(0, 4) == 0);
      v.flush  = ($urandom_range(0, 9) == 0);
      v.valid  = ($urandom_range(0, 4) != 0);
      v.rs1d   = $urandom;  v.rs2d = $urandom;
      v.iimm   = $urandom;  v.simm = $urandom;
      v.rs1a   = 5'($urandom); v.rs2a = 5'($urandom); v.rda = 5'($urandom);
      v.f3     = 3'($urandom);
      r = $urandom_range(0, 3);
      v.f7     = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : (r == 2) ? 7'h01 : 7'($urandom);
      v.wb     = 1'($urandom);
      v.mem    = 2'($urandom);
      v.aluop  = 2'($urandom);
      v.alusrc = 1'($urandom);
      return v;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 32'(valid_o),    32'(exp_s.valid));
      chk({tag, ".val1"},  val1_o,          exp_s.val1);
      chk({tag, ".val2"},  val2_o,          exp_s.val2);
      chk({tag, ".simm"},  simm_o,          exp_s.simm);
      chk({tag, ".alu"},   32'(alu_ctrl_o), 32'(exp_s.alu));
      chk({tag, ".rs1"},   32'(rs1_addr_o), 32'(exp_s.rs1));
      chk({tag, ".rs2"},   32'(rs2_addr_o), 32'(exp_s.rs2));
      chk({tag, ".rd"},    32'(rd_addr_o),  32'(exp_s.rd));
      chk({tag, ".wb"},    32'(wb_o),       32'(exp_s.wb));
      chk({tag, ".mem"},   32'(mem_o),      32'(exp_s.mem));
      chk({tag, ".ill"},   32'(illegal_o),  32'(exp_s.ill));
   endtask

   vec_t vecs[13];

   initial begin
      in_t v;
      out_t held;

      r_key[0] = 10'b0000000_000; r_code[0] = 4'b0010;
      r_key[1] = 10'b0100000_000; r_code[1] = 4'b0110;
      r_key[2] = 10'b0000000_111; r_code[2] = 4'b0000;
      r_key[3] = 10'b0000000_110; r_code[3] = 4'b0001;
      r_key[4] = 10'b0000000_100; r_code[4] = 4'b0011;
      r_key[5] = 10'b0000000_001; r_code[5] = 4'b0100;
      r_key[6] = 10'b0000000_101; r_code[6] = 4'b0101;
      r_key[7] = 10'b0100000_101; r_code[7] = 4'b0111;
      r_key[8] = 10'b0000000_010; r_code[8] = 4'b1000;
      r_key[9] = 10'b0000001_000; r_code[9] = 4'b1111;

      //                 aluop   f7      f3      vld wb  mem    src rs1 rs2 iimm simm
      vecs[0]  = '{mk(2'b10, 7'h20, 3'b000, 1, 1, 2'b00, 0, 7, 3, 9, 0),
                   4'b0110, 0, 1, 1, 2'b00, 32'd3};
      vecs[1]  = '{mk(2'b11, 7'h20, 3'b101, 1, 1, 2'b00, 1, 8, 5, 4, 0),
                   4'b0111, 0, 1, 1, 2'b00, 32'd4};
      vecs[2]  = '{mk(2'b11, 7'h01, 3'b101, 1, 1, 2'b00, 1, 8, 5, 4, 0),
                   4'b0010, 1, 1, 1, 2'b00, 32'd4};
      vecs[3]  = '{mk(2'b00, 7'h00, 3'b010, 1, 0, 2'b01, 1, 2, 6, 12, 32'hFFFFFFF8),
                   4'b0010, 0, 1, 0, 2'b01, 32'd12};
      vecs[4]  = '{mk(2'b01, 7'h00, 3'b000, 1, 0, 2'b00, 0, 1, 1, 0, 0),
                   4'b0110, 0, 1, 0, 2'b00, 32'd1};
      vecs[5]  = '{mk(2'b10, 7'h01, 3'b000, 1, 1, 2'b00, 0, 3, 4, 0, 0),
                   4'b1111, 0, 1, 1, 2'b00, 32'd4};
      vecs[6]  = '{mk(2'b10, 7'h00, 3'b010, 1, 1, 2'b00, 0, 3, 4, 0, 0),
                   4'b1000, 0, 1, 1, 2'b00, 32'd4};
      vecs[7]  = '{mk(2'b11, 7'h00, 3'b001, 1, 1, 2'b00, 1, 3, 4, 2, 0),
                   4'b0100, 0, 1, 1, 2'b00, 32'd2};
      vecs[8]  = '{mk(2'b11, 7'h20, 3'b001, 1, 1, 2'b00, 1, 3, 4, 2, 0),
                   4'b0010, 1, 1, 1, 2'b00, 32'd2};
      vecs[9]  = '{mk(2'b10, 7'h00, 3'b111, 1, 1, 2'b00, 0, 3, 32'hDEAD, 0, 0),
                   4'b0000, 0, 1, 1, 2'b00, 32'hDEAD};
      vecs[10] = '{mk(2'b10, 7'h00, 3'b101, 1, 1, 2'b00, 0, 3, 4, 0, 0),
                   4'b0101, 0, 1, 1, 2'b00, 32'd4};
      vecs[11] = '{mk(2'b11, 7'h55, 3'b100, 1, 1, 2'b00, 1, 3, 4, 32'h55, 0),
                   4'b0011, 0, 1, 1, 2'b00, 32'h55};
      vecs[12] = '{mk(2'b10, 7'h7F, 3'b000, 0, 1, 2'b10, 0, 3, 4, 0, 0),
                   4'b0010, 0, 0, 0, 2'b00, 32'd4};

      // Reset state.
      drive('0);
      exp_s = '0;
      #12;
      check_all("reset");
      rst_i = 1'b0;

      // Table-driven vectors: spec-derived constants plus full model check.
      for (int i = 0; i < 13; i++) begin
         apply(vecs[i].in);
         chk($sformatf("vec%0d.alu", i),   32'(alu_ctrl_o), 32'(vecs[i].e_alu));
         chk($sformatf("vec%0d.ill", i),   32'(illegal_o),  32'(vecs[i].e_ill));
         chk($sformatf("vec%0d.valid", i), 32'(valid_o),    32'(vecs[i].e_valid));
         chk($sformatf("vec%0d.wb", i),    32'(wb_o),       32'(vecs[i].e_wb));
         chk($sformatf("vec%0d.mem", i),   32'(mem_o),      32'(vecs[i].e_mem));
         chk($sformatf("vec%0d.val2", i),  val2_o,          vecs[i].e_val2);
         check_all($sformatf("vec%0d", i));
      end
      chk("store.simm", simm_o, exp_s.simm);

      // Stall holds for 3 cycles, then flush beats stall.
      apply(mk(2'b10, 7'h00, 3'b000, 1, 1, 2'b00, 0, 11, 22, 0, 0));
      held = exp_s;
      for (int i = 0; i < 3; i++) begin
         v = rnd_in();
         v.stall = 1'b1;
         v.flush = 1'b0;
         apply(v);
         chk("stall.wb_hold", 32'(wb_o), 32'(held.wb));
         chk("stall.val1_hold", val1_o, 32'd11);
         check_all("stall");
      end
      v = rnd_in();
      v.stall = 1'b1;
      v.flush = 1'b1;
      apply(v);
      chk("flush.alu", 32'(alu_ctrl_o), 32'h2);
      chk("flush.valid", 32'(valid_o), 32'h0);
      check_all("flush");

      // Reset asserted between edges acts immediately.
      v = mk(2'b10, 7'h00, 3'b000, 1, 1, 2'b10, 0, 1, 2, 0, 0);
      v.rda = 5'd5;
      apply(v);
      chk("prerst.rd", 32'(rd_addr_o), 32'd5);
      #2;
      rst_i = 1'b1;
      exp_s = '0;
      #1;
      check_all("async_rst");
      #1;
      rst_i = 1'b0;

      // Randomized stimulus against the model.
      for (int i = 0; i < 300; i++) begin
         apply(rnd_in());
         check_all($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/idex_stage_reg.md
Name: idex_stage_reg

Overview:
- Registered ID/EX pipeline boundary for the 5-stage RISC-V core.
- Captures decoded operands and control from ID, resolves the ALU operand-2 mux and ALU control code, and presents them to EX one cycle later.
- Extends the earlier combinational boundary with parametrised widths, an I-type ALU decode mode, stall hold, flush bubble insertion, a valid bit, and an illegal-op flag.
- Has no latches: every decode path is fully specified.

Parameters:
- XLEN, 32, datapath width of operands and immediates.
- RADDR_W, 5, register-file address width.

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- stall_i  in  1  hold current contents (hazard unit).
- flush_i  in  1  load a bubble (branch taken / exception).
- valid_i  in  1  ID holds a real instruction.
- rs1_data_i  in  XLEN  register-file read data 1.
- rs2_data_i  in  XLEN  register-file read data 2.
- iimm_i  in  XLEN  sign-extended I-immediate.
- simm_i  in  XLEN  sign-extended S-immediate.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  RADDR_W each  register addresses.
- funct3_i  in  3  instruction funct3.
- funct7_i  in  7  instruction funct7.
- wb_i  in  1  RegWrite.
- mem_i  in  2  {MemRead, MemWrite}.
- aluop_i  in  2  ALU operation class.
- alusrc_i  in  1  1 = immediate as operand 2.
- valid_o  out  1  EX holds a real instruction.
- val1_o  out  XLEN  registered rs1_data.
- val2_o  out  XLEN  registered (alusrc ? iimm : rs2_data).
- simm_o  out  XLEN  registered S-immediate.
- alu_ctrl_o  out  4  registered ALU control code.
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  RADDR_W each  registered addresses.
- wb_o  out  1  registered RegWrite.
- mem_o  out  2  registered mem control.
- illegal_o  out  1  registered unsupported-encoding flag.

Behaviour:
- Reset (rst_i=1, async): every output is 0, so valid_o=0, wb_o=0, mem_o=00, alu_ctrl_o=0000, illegal_o=0.
- Latency is 1 cycle: the decode runs combinationally on the inputs and the result is captured on the rising clk_i edge.
- Edge priority is reset > flush > stall > load.
  - flush_i=1: bubble loaded. valid_o, wb_o, mem_o, illegal_o, all data and address outputs are 0, and alu_ctrl_o=0010. Flush beats a simultaneous stall.
  - stall_i=1 (no flush): all outputs hold their values.
  - Otherwise: load. valid_o=valid_i. When valid_i=0, wb_o and mem_o are forced to 0 and illegal_o=0; data fields are loaded as given.
- ALU codes: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 0111, SLT 1000, MUL 1111.
- aluop 00 (load/store): ADD.
- aluop 01 (branch): SUB.
- aluop 10 (R-type), decoded on {funct7,funct3}:
  - 0000000_000 ADD; 0100000_000 SUB; 0000000_111 AND; 0000000_110 OR; 0000000_100 XOR.
  - 0000000_001 SLL; 0000000_101 SRL; 0100000_101 SRA; 0000000_010 SLT; 0000001_000 MUL.
- aluop 11 (I-type), decoded on funct3, with funct7 checked only for shifts:
  - 000 ADD; 111 AND; 110 OR; 100 XOR; 010 SLT.
  - 001 requires funct7=0000000 and gives SLL.
  - 101 with funct7=0000000 gives SRL; with 0100000 gives SRA.
- Any other combination decodes to ADD with illegal flag 1. The flag is registered only when valid_i=1.
- val2 mux is selected by alusrc_i before the register. No arithmetic happens here; widths pass through unchanged.

Decomposition:
- Package idex_pkg holds:
  - ALU code localparams (ALU_ADD … ALU_MUL).
  - ALUOp class localparams (ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_I).
  - The bubble ALU code.
- Sub-module alu_ctrl_dec is purely combinational: inputs aluop, funct3, funct7; outputs alu_ctrl and illegal. It is instantiated once, ahead of the register.

Test Plan:
- Reset mid-operation: after loading rd_addr_i=5, wb_i=1, assert rst_i between edges -> all outputs 0 immediately, without waiting for a clock edge.
- R-type SUB: aluop=10, funct7=0100000, funct3=000, rs1=7, rs2=3, alusrc=0, valid=1 -> next edge: alu_ctrl_o=0110, val1_o=7, val2_o=3, valid_o=1, illegal_o=0.
- I-type SRAI: aluop=11, funct3=101, funct7=0100000, iimm=4, alusrc=1 -> alu_ctrl_o=0111, val2_o=4. Repeat with funct7=0000001 -> alu_ctrl_o=0010, illegal_o=1.
- Stall then flush: load ADD with wb=1; hold stall_i=1 for 3 cycles with new inputs -> outputs unchanged. Then flush_i=1 with stall_i=1 -> valid_o=0, wb_o=0, mem_o=00, alu_ctrl_o=0010.
- Store path: aluop=00, mem_i=01, simm=-8 (0xFFFFFFF8) -> alu_ctrl_o=0010, mem_o=01, simm_o=0xFFFFFFF8.
- Invalid slot: valid_i=0, wb_i=1, mem_i=10, unsupported R-type funct -> valid_o=0, wb_o=0, mem_o=00, illegal_o=0.
